apu_frame_sequencer: RTL
========================

Name: apu_frame_sequencer

Overview:
- Sound-timing controller: divides the AC97 bit clock into the 512 Hz Game Boy frame sequencer.
- Issues one-cycle length, sweep and envelope strobes to the channel blocks.
- Owns the length counters and channel-on flags for channels 1-4, which are triggered by the chN_reset bits from sound_registers.
- Sits beside sound_registers and drives WaveformPlayer and the square/noise channel blocks. Replaces the ad-hoc chained clock dividers.

Parameters:
- DIV_COUNT, 24000, bit-clock cycles per sequencer step (12.288 MHz / 512 Hz).
- DIV_SIZE, 15, prescaler width; must satisfy 2^DIV_SIZE >= DIV_COUNT.

Ports:
- clk  in  1  AC97 bit clock; all logic on rising edge.
- reset  in  1  asynchronous, active-high.
- sound_master_enable  in  1  NR52 bit 7.
- ch1_reset, ch2_reset, ch3_reset, ch4_reset  in  1 each  channel trigger bits (levels).
- ch1_length_data, ch2_length_data, ch4_length_data  in  6 each  length register fields.
- ch3_length_data  in  8  wave channel length field.
- ch1_dont_loop, ch2_dont_loop, ch3_dont_loop, ch4_dont_loop  in  1 each  length-enable bits.
- step  out  3  current sequencer step 0-7.
- length_tick  out  1  256 Hz strobe.
- sweep_tick  out  1  128 Hz strobe.
- envelope_tick  out  1  64 Hz strobe.
- ch1_on_flag, ch2_on_flag, ch3_on_flag, ch4_on_flag  out  1 each  channel active flags, routed to NR52.

Behaviour:
- Reset (async, active-high):
  - prescaler=0, step=0, all ticks=0.
  - All on_flags=0, all length counters=0, trigger edge registers=0.
- Prescaler:
  - While enabled, counts 0..DIV_COUNT-1, then wraps to 0.
  - On the wrap edge, step <= step+1 mod 8.
- Tick schedule: ticks are registered and high for exactly the one cycle in which step holds its new value.
  - Enter step 0, 2, 4 or 6: length_tick.
  - Enter step 2 or 6: sweep_tick as well.
  - Enter step 7: envelope_tick.
  - Steps 1, 3, 5: no tick.
  - The first length_tick after reset occurs on entry to step 2, i.e. 2*DIV_COUNT cycles after reset release.
- Trigger detect:
  - Each chN_reset is sampled every cycle.
  - A trigger is chN_reset=1 while its previous-cycle sample=0 (rising edge).
  - A held-high level produces only one trigger.
- On trigger of channel N:
  - Counter loads 64-length_data (7-bit counter, range 1..64); for ch3, 256-length_data (9-bit counter, range 1..256).
  - on_flag <= 1 on the same clock edge.
  - Latency: flag visible 1 cycle after chN_reset first samples high.
- On length_tick with chN_dont_loop=1 and counter>0:
  - Counter decrements.
  - If the decremented value is 0, on_flag <= 0 on the same edge.
- With chN_dont_loop=0: counter frozen, on_flag unchanged.
- Trigger and length_tick in the same cycle: trigger wins; full value loaded, no decrement that cycle.
- Counter==0 with on_flag=0: further ticks have no effect; no underflow.
- sound_master_enable=0:
  - prescaler and step forced to 0, ticks forced to 0.
  - All on_flags and counters cleared; triggers ignored.
  - Edge registers keep sampling, so a reset bit already high at re-enable does not trigger.
- sound_master_enable 0->1: sequencer restarts from step 0 with prescaler 0; next step entered is 1.
- Mid-operation reset assertion: everything returns to its reset values immediately (asynchronous).
- Outputs are all registered; no combinational path from input to output.

Test Plan:
- DIV_COUNT=4, master enable=1, release reset -> step sequence 1,2,...,7,0 advancing every 4 cycles. length_tick on entry to steps 2,4,6,0; sweep_tick on 2,6; envelope_tick on 7. Each tick exactly 1 cycle wide.
- ch1_length_data=62, dont_loop=1, pulse ch1_reset -> ch1_on_flag=1 one cycle later; counter=2. Cleared on the 2nd subsequent length_tick edge.
- ch3_length_data=0, dont_loop=1, trigger -> ch3_on_flag stays high for 255 length_ticks and drops on the 256th.
- ch2 triggered with dont_loop=0 -> flag stays 1 across 100 length_ticks. Set dont_loop=1 -> decrement resumes from the frozen value.
- ch4 trigger rising in the same cycle as a length_tick -> counter=64-length_data with no decrement; hold ch4_reset high for 10 cycles -> no retrigger.
- Drop sound_master_enable mid-step with flags set -> step=0, all flags=0 next edge. Hold ch1_reset high across re-enable -> no trigger. Assert reset mid-count -> all outputs 0 immediately.

Source files
------------

// File: rtl/apu_frame_sequencer.sv
// 512 Hz frame sequencer with length counters and channel-on flags.
// Prescales the bit clock and strobes length, sweep and envelope ticks.
module apu_length_counter #(
    parameter int DW = 6,
    parameter int CW = 7
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          enable,
    input  logic          trig_level,
    input  logic          dont_loop,
    input  logic          tick,
    input  logic [DW-1:0] length_data,
    output logic          on_flag
);

    localparam logic [CW-1:0] FULL = CW'(1 << (CW - 1));

    logic          prev;
    logic [CW-1:0] cnt;
    logic [CW-1:0] load;
    logic          trig;

    assign load = {{(CW - DW){1'b0}}, length_data};
    assign trig = trig_level & ~prev;

    // Edge sampling runs even while disabled so a held bit cannot retrigger.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            prev    <= 1'b0;
            cnt     <= '0;
            on_flag <= 1'b0;
        end else begin
            prev <= trig_level;
            if (!enable) begin
                cnt     <= '0;
                on_flag <= 1'b0;
            end else if (trig) begin
                cnt     <= FULL - load;
                on_flag <= 1'b1;
            end else if (tick && dont_loop && cnt != '0) begin
                cnt <= cnt - CW'(1);
                if (cnt == CW'(1)) begin
                    on_flag <= 1'b0;
                end
            end
        end
    end

endmodule

module apu_frame_sequencer #(
    parameter int DIV_COUNT = 24000,
    parameter int DIV_SIZE  = 15
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       sound_master_enable,
    input  logic       ch1_reset,
    input  logic       ch2_reset,
    input  logic       ch3_reset,
    input  logic       ch4_reset,
    input  logic [5:0] ch1_length_data,
    input  logic [5:0] ch2_length_data,
    input  logic [7:0] ch3_length_data,
    input  logic [5:0] ch4_length_data,
    input  logic       ch1_dont_loop,
    input  logic       ch2_dont_loop,
    input  logic       ch3_dont_loop,
    input  logic       ch4_dont_loop,
    output logic [2:0] step,
    output logic       length_tick,
    output logic       sweep_tick,
    output logic       envelope_tick,
    output logic       ch1_on_flag,
    output logic       ch2_on_flag,
    output logic       ch3_on_flag,
    output logic       ch4_on_flag
);

    logic [DIV_SIZE-1:0] prescaler;
    logic                wrap;
    logic [2:0]          next_step;

    assign wrap      = prescaler == DIV_SIZE'(DIV_COUNT - 1);
    assign next_step = step + 3'd1;

    // Prescaler and step; ticks fire only in the first cycle of a new step.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            prescaler     <= '0;
            step          <= 3'd0;
            length_tick   <= 1'b0;
            sweep_tick    <= 1'b0;
            envelope_tick <= 1'b0;
        end else if (!sound_master_enable) begin
            prescaler     <= '0;
            step          <= 3'd0;
            length_tick   <= 1'b0;
            sweep_tick    <= 1'b0;
            envelope_tick <= 1'b0;
        end else if (wrap) begin
            prescaler     <= '0;
            step          <= next_step;
            length_tick   <= ~next_step[0];
            sweep_tick    <= next_step[1:0] == 2'b10;
            envelope_tick <= next_step == 3'd7;
        end else begin
            prescaler     <= prescaler + DIV_SIZE'(1);
            length_tick   <= 1'b0;
            sweep_tick    <= 1'b0;
            envelope_tick <= 1'b0;
        end
    end

    apu_length_counter #(.DW(6), .CW(7)) u_ch1 (
        .clk        (clk),
        .reset      (reset),
        .enable     (sound_master_enable),
        .trig_level (ch1_reset),
        .dont_loop  (ch1_dont_loop),
        .tick       (length_tick),
        .length_data(ch1_length_data),
        .on_flag    (ch1_on_flag)
    );

    apu_length_counter #(.DW(6), .CW(7)) u_ch2 (
        .clk        (clk),
        .reset      (reset),
        .enable     (sound_master_enable),
        .trig_level (ch2_reset),
        .dont_loop  (ch2_dont_loop),
        .tick       (length_tick),
        .length_data(ch2_length_data),
        .on_flag    (ch2_on_flag)
    );

    apu_length_counter #(.DW(8), .CW(9)) u_ch3 (
        .clk        (clk),
        .reset      (reset),
        .enable     (sound_master_enable),
        .trig_level (ch3_reset),
        .dont_loop  (ch3_dont_loop),
        .tick       (length_tick),
        .length_data(ch3_length_data),
        .on_flag    (ch3_on_flag)
    );

    apu_length_counter #(.DW(6), .CW(7)) u_ch4 (
        .clk        (clk),
        .reset      (reset),
        .enable     (sound_master_enable),
        .trig_level (ch4_reset),
        .dont_loop  (ch4_dont_loop),
        .tick       (length_tick),
        .length_data(ch4_length_data),
        .on_flag    (ch4_on_flag)
    );

endmodule
